// File: rtl/ext_in_debouncer.sv
// Synchronise, debounce and glitch-count the external EXT pin for the PIO.
// Optional glitch counter enabled by defining EXT_IN_GLITCH_CNT_EN.
module ext_in_debouncer #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16,
  parameter int THR_RESET   = 1000,
  parameter int GLITCH_W    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ext_in,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        debounced_out
);

  typedef enum logic [1:0] {
    ST_LOW  = 2'b00,
    WAIT_HI = 2'b01,
    ST_HIGH = 2'b10,
    WAIT_LO = 2'b11
  } state_t;

  state_t               state;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                 sync_q;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [CNT_WIDTH-1:0] thr;
  logic [CNT_WIDTH-1:0] thr_eff;
  logic [GLITCH_W-1:0]  glitch;
  logic                 wr;
  logic [31:0]          rd_mux;
  logic                 unused_ok;

  assign unused_ok = ^writedata;
  assign sync_q    = sync_r[SYNC_STAGES-1];
  assign thr_eff   = (thr == '0) ? CNT_WIDTH'(1) : thr;
  assign cnt_inc   = (cnt == '1) ? cnt : cnt + CNT_WIDTH'(1);
  assign wr        = chipselect && !write_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], ext_in};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_LOW;
      cnt           <= '0;
      debounced_out <= 1'b0;
    end else begin
      unique case (state)
        ST_LOW: begin
          if (sync_q) begin
            state <= WAIT_HI;
            cnt   <= CNT_WIDTH'(1);
          end
        end
        WAIT_HI: begin
          if (!sync_q) begin
            state <= ST_LOW;
            cnt   <= '0;
          end else if (cnt >= thr_eff) begin
            state         <= ST_HIGH;
            debounced_out <= 1'b1;
            cnt           <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_HIGH: begin
          if (!sync_q) begin
            state <= WAIT_LO;
            cnt   <= CNT_WIDTH'(1);
          end
        end
        WAIT_LO: begin
          if (sync_q) begin
            state <= ST_HIGH;
            cnt   <= '0;
          end else if (cnt >= thr_eff) begin
            state         <= ST_LOW;
            debounced_out <= 1'b0;
            cnt           <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= ST_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      thr <= CNT_WIDTH'(THR_RESET);
    end else if (wr && address == 2'd1) begin
      thr <= writedata[CNT_WIDTH-1:0];
    end
  end

`ifdef EXT_IN_GLITCH_CNT_EN
  logic glitch_ev;

  // A level that reverts before qualifying is a glitch.
  assign glitch_ev = (state == WAIT_HI && !sync_q) ||
                     (state == WAIT_LO && sync_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      glitch <= '0;
    end else if (wr && address == 2'd2) begin
      glitch <= '0;
    end else if (glitch_ev && glitch != '1) begin
      glitch <= glitch + GLITCH_W'(1);
    end
  end
`else
  assign glitch = '0;
`endif

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[3:0] = {state, sync_q, debounced_out};
      2'd1:    rd_mux[CNT_WIDTH-1:0] = thr;
      2'd2:    rd_mux[GLITCH_W-1:0] = glitch;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_ext_in_debouncer.sv
// Scoreboard bench for ext_in_debouncer against a run-length debounce model.
// Glitch counter narrowed to 8 bits so saturation is reachable quickly.
module tb_ext_in_debouncer;

  localparam int SS      = 2;
  localparam int CW      = 16;
  localparam int THR_RST = 1000;
  localparam int GW      = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ext_in;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        debounced_out;

  always #5 clk = ~clk;

  ext_in_debouncer #(
    .SYNC_STAGES(SS),
    .CNT_WIDTH(CW),
    .THR_RESET(THR_RST),
    .GLITCH_W(GW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ext_in(ext_in),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .debounced_out(debounced_out)
  );

  typedef struct {
    logic        o;
    logic [31:0] rd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  // Model: out flips once the synced level has differed from it
  // for thr_eff+1 consecutive clocks; an earlier revert is a glitch.
  int m_thr;
  int m_run;
  bit m_out;
  int m_gl;
  bit sh[SS];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_thr = THR_RST;
    m_run = 0;
    m_out = 1'b0;
    m_gl  = 0;
    for (int i = 0; i < SS; i++) sh[i] = 1'b0;
  endtask

  task automatic step(bit e, bit cs, bit wn, logic [1:0] a, logic [31:0] wd);
    bit          sq;
    int          te;
    logic [1:0]  st;
    logic [31:0] rd;
    exp_t        x;
    @(negedge clk);
    ext_in     = e;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    sq = sh[SS-1];
    te = (m_thr == 0) ? 1 : m_thr;
    if (m_run == 0) st = m_out ? 2'd2 : 2'd0;
    else            st = m_out ? 2'd3 : 2'd1;
    rd = '0;
    case (a)
      2'd0: rd = {28'd0, st, sq, m_out};
      2'd1: rd = 32'(m_thr);
`ifdef EXT_IN_GLITCH_CNT_EN
      2'd2: rd = 32'(m_gl);
`endif
      default: rd = '0;
    endcase
    if (sq != m_out) begin
      if (m_run >= te) begin
        m_out = !m_out;
        m_run = 0;
      end else if (m_run < 65535) begin
        m_run++;
      end
    end else if (m_run > 0) begin
      m_run = 0;
      if (m_gl < (1 << GW) - 1) m_gl++;
    end
    if (cs && !wn) begin
      if (a == 2'd1) m_thr = int'(wd[CW-1:0]);
      if (a == 2'd2) m_gl = 0;
    end
    for (int i = SS - 1; i > 0; i--) sh[i] = sh[i-1];
    sh[0] = e;
    x.o  = m_out;
    x.rd = rd;
    q.push_back(x);
  endtask

  task automatic idle(bit e, logic [1:0] a);
    step(e, 1'b0, 1'b1, a, 32'h0);
  endtask

  task automatic wr(bit e, logic [1:0] a, logic [31:0] d);
    step(e, 1'b1, 1'b0, a, d);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("debounced_out", {31'd0, debounced_out}, {31'd0, e.o});
        chk("readdata", readdata, e.rd);
      end
    end
  end

  initial begin : stim
    bit lvl;
    int hold;
    int r;
    reset_n    = 1'b0;
    ext_in     = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out", {31'd0, debounced_out}, 32'd0);
    chk("reset_readdata", readdata, 32'd0);
    reset_n = 1'b1;

    idle(1'b0, 2'd1);
    idle(1'b0, 2'd0);
    idle(1'b0, 2'd2);
    idle(1'b0, 2'd3);

    wr(1'b0, 2'd1, 32'd4);
    repeat (12) idle(1'b1, 2'd0);
    repeat (12) idle(1'b0, 2'd0);

    repeat (3) idle(1'b1, 2'd0);
    repeat (8) idle(1'b0, 2'd2);

    wr(1'b0, 2'd1, 32'd0);
    repeat (6) idle(1'b1, 2'd0);
    repeat (6) idle(1'b0, 2'd1);

    wr(1'b0, 2'd1, 32'd3);
    for (int i = 0; i < 600; i++) idle(i[0], 2'd2);
    wr(1'b0, 2'd2, 32'd0);
    repeat (2) idle(1'b0, 2'd2);
    for (int i = 0; i < 40; i++)
      step(i[0], (i % 5) == 0, (i % 5) != 0, 2'd2, 32'hFFFF_FFFF);
    repeat (3) idle(1'b0, 2'd2);

    wr(1'b0, 2'd1, 32'd100);
    repeat (51) idle(1'b1, 2'd0);
    wr(1'b1, 2'd1, 32'd10);
    repeat (3) idle(1'b1, 2'd0);
    repeat (120) idle(1'b0, 2'd0);

    lvl  = 1'b0;
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        lvl  = $urandom_range(0, 1) == 1;
        hold = $urandom_range(1, 10);
      end
      hold--;
      r = $urandom_range(0, 19);
      if (r == 0)
        wr(lvl, 2'd1, {$urandom, 3'b000} | 32'($urandom_range(0, 6)) & 32'h7);
      else if (r == 1)
        wr(lvl, 2'd2, $urandom);
      else if (r == 2)
        wr(lvl, ($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0, $urandom);
      else
        idle(lvl, 2'($urandom_range(0, 3)));
    end

    wr(1'b0, 2'd1, 32'd2);
    repeat (10) idle(1'b1, 2'd0);
    wr(1'b1, 2'd1, 32'd100);
    repeat (6) idle(1'b0, 2'd0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_out", {31'd0, debounced_out}, 32'd0);
    chk("async_reset_readdata", readdata, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    ext_in  = 1'b0;
    idle(1'b0, 2'd0);
    idle(1'b0, 2'd1);
    idle(1'b0, 2'd0);

    repeat (3) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
